// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave register block: FSM state type and
// default parameter values used by the top and its register file.
package apb_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } slv_state_t;

    localparam int unsigned DEF_ADDR_WIDTH  = 32;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_DEPTH       = 16;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam logic [31:0] DEF_ID_VALUE    = 32'hA0B0_0001;

    localparam int unsigned CNT_WIDTH = 4;

endpackage

// File: rtl/apb_regfile.sv
// Word register file: entry 0 is a read-only ID constant, entries 1..DEPTH-1
// are writable and cleared by reset.
module apb_regfile import apb_pkg::*; #(
    parameter int unsigned             DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned             DEPTH      = DEF_DEPTH,
    parameter logic [DATA_WIDTH-1:0]   ID_VALUE   = DEF_ID_VALUE,
    localparam int unsigned            IDX_W      = $clog2(DEPTH)
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Entry 0 is never written; its storage only exists to keep indexing uniform.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_idx != '0)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = mem[rd_idx];
        if (rd_idx == '0) begin
            rd_data = ID_VALUE;
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a small word register file and a fixed number of access-phase
// wait states; bus fields are captured at setup and govern the whole transfer.
module apb_slave_mem import apb_pkg::*; #(
    parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned           DEPTH       = DEF_DEPTH,
    parameter int unsigned           WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DEF_ID_VALUE
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] prdata
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    slv_state_t             state;
    slv_state_t             state_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic                   lat_write;
    logic [DATA_WIDTH-1:0]  lat_wdata;

    logic                   setup;
    logic                   in_access;
    logic                   done;
    logic [IDX_W-1:0]       idx;
    logic                   addr_err;
    logic                   err;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  rd_data;

    assign setup     = pselx && !penable;
    assign in_access = pselx && penable;
    assign done      = (state == ACCESS) && (cnt == '0);
    assign idx       = lat_addr[IDX_W+1:2];
    // Any address bit above the index field makes the word index >= DEPTH.
    assign addr_err  = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (IDX_W + 2)) != '0);
    assign err       = addr_err || (lat_write && (idx == '0));

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && setup) begin
                lat_addr  <= paddr;
                lat_write <= pwrite;
                lat_wdata <= pwdata;
                cnt       <= CNT_WIDTH'(WAIT_CYCLES);
            end else if ((state == ACCESS) && (cnt != '0) && in_access) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else if (!in_access) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even mid-transfer.
    always_comb begin
        pready  = done && !preset;
        pslverr = pready && err;
        wr_en   = pready && lat_write && !err;
        prdata  = '0;
        if (pready && !lat_write && !err) begin
            prdata = rd_data;
        end
    end

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .pclk    (pclk),
        .preset  (preset),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (lat_wdata),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the paddr width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the pwdata/prdata width.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning the number of word registers (power of 2, at least 2).
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the access-phase wait states inserted before pready (0..15).
REQ-005 The block SHALL have parameter ID_VALUE, default 32'hA0B0_0001, meaning the constant returned by register 0.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 The block SHALL have port pclk, input, 1 bit: the clock; all state changes on the rising edge.
REQ-008 The block SHALL have port preset, input, 1 bit: synchronous active-high reset.
REQ-009 The block SHALL have port pselx, input, 1 bit: slave select.
REQ-010 The block SHALL have port penable, input, 1 bit: access phase indicator.
REQ-011 The block SHALL have port pwrite, input, 1 bit: 1 for write, 0 for read.
REQ-012 The block SHALL have port paddr, input, ADDR_WIDTH bits: byte address.
REQ-013 The block SHALL have port pwdata, input, DATA_WIDTH bits: write data.
REQ-014 The block SHALL have port pready, output, 1 bit: transfer complete.
REQ-015 The block SHALL have port pslverr, output, 1 bit: transfer error, qualified by pready.
REQ-016 The block SHALL have port prdata, output, DATA_WIDTH bits: read data, qualified by pready and !pwrite.

Function
REQ-017 The FSM SHALL have two states, IDLE and ACCESS, plus a wait counter of 4 bits.
REQ-018 In IDLE, on pselx=1 and penable=0 (setup phase), the block SHALL latch paddr, pwrite and pwdata, load the counter with WAIT_CYCLES, and go to ACCESS.
REQ-019 In IDLE, pselx=1 with penable=1 (no setup seen) SHALL be ignored: stay in IDLE with pready=0.
REQ-020 pready SHALL be a Moore output equal to (state==ACCESS and counter==0), so it asserts exactly WAIT_CYCLES+1 cycles after the setup cycle.
REQ-021 In ACCESS with counter>0 and pselx=penable=1, the counter SHALL decrement by 1 per cycle.
REQ-022 In ACCESS, if pselx=0 or penable=0 before completion, the transfer SHALL be aborted: return to IDLE with no write committed.
REQ-023 On the pready cycle, the FSM SHALL return to IDLE, so a setup in the very next cycle is accepted (back-to-back transfers).
REQ-024 The latched address SHALL be an error if paddr[1:0]!=0 or the word index is >= DEPTH (any upper bit set).
REQ-025 A write to index 0 (the read-only ID register) SHALL be an error.
REQ-026 A valid write SHALL update register[index] with the latched pwdata at the end of the pready cycle.
REQ-027 An erroring write SHALL modify no register.
REQ-028 prdata SHALL be register[index] (ID_VALUE for index 0) during a valid read pready cycle, and 0 in all other cycles, including error cycles.
REQ-029 pslverr SHALL equal pready AND error, and SHALL be 0 whenever pready is 0.
REQ-030 Bus inputs that change during ACCESS SHALL be ignored; the latched values govern the transfer.

Reset
REQ-031 While preset=1, the FSM SHALL go to IDLE and the counter to 0.
REQ-032 While preset=1, registers 1..DEPTH-1 SHALL be cleared to 0.
REQ-033 While preset=1, pready, pslverr and prdata SHALL all read 0.
REQ-034 A reset during ACCESS SHALL abort the transfer with no write committed.

Structure
REQ-035 The shared package apb_pkg SHALL hold the state enum slv_state_t (IDLE, ACCESS) and the default width constants.
REQ-036 Register storage, including write-enable, read mux and the ID constant, SHALL be a sub-module named apb_regfile.

Verification
REQ-037 Write then read, WAIT_CYCLES=2: write 0x0000_0008 <= 0xDEAD_BEEF -> pready on the 3rd cycle after setup with pslverr=0; the following read returns prdata=0xDEAD_BEEF.
REQ-038 ID read and protection: read 0x0 -> prdata=0xA0B0_0001; write 0x0 <= 0x1234 -> pslverr=1, and a re-read still returns 0xA0B0_0001.
REQ-039 Errors: read 0x0000_0042 (unaligned) and read 0x0000_0040 (index 16) -> pslverr=1, prdata=0.
REQ-040 Abort: drop pselx in the 2nd access cycle of a write to 0x4 <= 0x55 -> no pready, and reading 0x4 afterwards returns 0.
REQ-041 Back-to-back with WAIT_CYCLES=0: alternating writes and reads with setup immediately after pready -> pready on every access cycle, data correct.
REQ-042 Mid-write reset: assert preset during ACCESS of a write to 0xC -> outputs 0; after reset, reading 0xC returns 0.
